// File: rtl/io_switch_debounce.sv
// Two-bank slide-switch conditioner: synchronise each raw bank, debounce it as a whole word,
// and present settled values with a one-cycle change strobe to the I/O input port block.

module io_switch_debounce_bank #(
    parameter int WIDTH      = 5,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 500000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_val,
    output logic             o_chg
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_cand;
    logic [WIDTH-1:0] r_val;
    logic [CNT_W-1:0] r_cnt;
    logic             r_chg;

    // Synchroniser, candidate tracking and whole-word debounce counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1   <= {WIDTH{1'b0}};
            r_s2   <= {WIDTH{1'b0}};
            r_cand <= {WIDTH{1'b0}};
            r_val  <= {WIDTH{1'b0}};
            r_cnt  <= {CNT_W{1'b0}};
            r_chg  <= 1'b0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_cand <= r_s2;
            r_chg  <= 1'b0;
            // A value equal to the accepted one, or one still moving, never counts
            if (r_s2 == r_val) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_s2 != r_cand) begin
                r_cnt <= {CNT_W{1'b0}};
            end else if (r_cnt == LP_CNT_LAST) begin
                r_val <= r_s2;
                r_cnt <= {CNT_W{1'b0}};
                r_chg <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_val = r_val;
    assign o_chg = r_chg;

endmodule

module io_switch_debounce #(
    parameter int WIDTH      = 5,
    parameter int CNT_W      = 20,
    parameter int STABLE_CNT = 500000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_raw0,
    input  logic [WIDTH-1:0] sw_raw1,
    output logic [WIDTH-1:0] in_port0,
    output logic [WIDTH-1:0] in_port1,
    output logic             chg0,
    output logic             chg1
);

    io_switch_debounce_bank #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_bank0 (
        .clk    (clk),
        .resetn (resetn),
        .i_raw  (sw_raw0),
        .o_val  (in_port0),
        .o_chg  (chg0)
    );

    io_switch_debounce_bank #(
        .WIDTH      (WIDTH),
        .CNT_W      (CNT_W),
        .STABLE_CNT (STABLE_CNT)
    ) u_bank1 (
        .clk    (clk),
        .resetn (resetn),
        .i_raw  (sw_raw1),
        .o_val  (in_port1),
        .o_chg  (chg1)
    );

endmodule

// File: tb/tb_io_switch_debounce.sv
// Scoreboard bench for io_switch_debounce with STABLE_CNT=4: expected acceptances are queued
// when the switches are driven and retired when the matching change strobe appears.

module tb_io_switch_debounce;

    localparam int WIDTH   = 5;
    localparam int LATENCY = 7;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               edge_no;
    } exp_t;

    logic             clk;
    logic             resetn;
    logic [WIDTH-1:0] sw_raw0;
    logic [WIDTH-1:0] sw_raw1;
    logic [WIDTH-1:0] in_port0;
    logic [WIDTH-1:0] in_port1;
    logic             chg0;
    logic             chg1;

    int   n_checks = 0;
    int   n_errors = 0;
    int   edge_n   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [WIDTH-1:0] exp0 = '0;
    logic [WIDTH-1:0] exp1 = '0;

    io_switch_debounce #(
        .WIDTH      (WIDTH),
        .CNT_W      (20),
        .STABLE_CNT (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .sw_raw0  (sw_raw0),
        .sw_raw1  (sw_raw1),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .chg0     (chg0),
        .chg1     (chg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, edge_n);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive0(input logic [WIDTH-1:0] v, input bit push);
        exp_t e;
        sw_raw0 = v;
        if (push) begin
            e.val = v;
            e.edge_no = edge_n + LATENCY;
            q0.push_back(e);
        end
    endtask

    task automatic drive1(input logic [WIDTH-1:0] v, input bit push);
        exp_t e;
        sw_raw1 = v;
        if (push) begin
            e.val = v;
            e.edge_no = edge_n + LATENCY;
            q1.push_back(e);
        end
    endtask

    // Output monitor: retire queued acceptances on strobes, and hold outputs steady otherwise
    always @(negedge clk) begin
        exp_t e;
        if (!resetn) begin
            exp0 = '0;
            exp1 = '0;
        end else begin
            if (chg0) begin
                if (q0.size() == 0) begin
                    check("chg0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    check("in_port0_value", in_port0, e.val);
                    check("chg0_edge", edge_n, e.edge_no);
                    exp0 = e.val;
                end
            end
            if (chg1) begin
                if (q1.size() == 0) begin
                    check("chg1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    check("in_port1_value", in_port1, e.val);
                    check("chg1_edge", edge_n, e.edge_no);
                    exp1 = e.val;
                end
            end
            check("in_port0_hold", in_port0, exp0);
            check("in_port1_hold", in_port1, exp1);
        end
    end

    task automatic check_drained(input string tag);
        check({tag, "_q0_pending"}, q0.size(), 0);
        check({tag, "_q1_pending"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    initial begin
        resetn  = 1'b0;
        sw_raw0 = 5'h1F;
        sw_raw1 = 5'h0A;
        #1;
        check("reset_in_port0", in_port0, 0);
        check("reset_in_port1", in_port1, 0);
        check("reset_chg0", chg0, 0);
        check("reset_chg1", chg1, 0);
        sw_raw0 = 5'd0;
        sw_raw1 = 5'd0;
        step(3);
        resetn = 1'b1;
        step(3);

        // Clean step on bank 0
        drive0(5'd23, 1'b1);
        step(10);
        check("clean_in_port0", in_port0, 23);
        check("clean_in_port1", in_port1, 0);
        check_drained("clean");

        // Short glitch on bank 0 must be rejected
        drive0(5'd7, 1'b0);
        step(3);
        drive0(5'd23, 1'b0);
        step(10);
        check("glitch_in_port0", in_port0, 23);
        check_drained("glitch");

        // Bouncing bank 1 settles on 12
        for (int i = 0; i < 10; i++) begin
            drive1(((i % 2) == 0) ? 5'd12 : 5'd0, 1'b0);
            step(1);
        end
        drive1(5'd12, 1'b1);
        step(12);
        check("bounce_in_port1", in_port1, 12);
        check_drained("bounce");

        // Both banks change together
        drive0(5'd3, 1'b1);
        drive1(5'd31, 1'b1);
        step(10);
        check("simul_in_port0", in_port0, 3);
        check("simul_in_port1", in_port1, 31);
        check_drained("simul");

        // Reset in the middle of a count; both banks must re-settle from zero
        drive0(5'd9, 1'b0);
        step(4);
        resetn = 1'b0;
        #1;
        check("midrst_in_port0", in_port0, 0);
        check("midrst_in_port1", in_port1, 0);
        step(2);
        resetn = 1'b1;
        drive0(5'd9, 1'b1);
        drive1(5'd31, 1'b1);
        step(12);
        check("midrst_final_port0", in_port0, 9);
        check("midrst_final_port1", in_port1, 31);
        check_drained("midrst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
